// File: rtl/jtcps2_keyctrl_if.sv
// Downloader sniff bus and keyload feed bundle for jtcps2_keyctrl.
interface jtcps2_keyctrl_if #(parameter int AW = 25);
    logic          downloading;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_wr;
    logic [7:0]    key_din;
    logic          key_we;
    logic [4:0]    key_cnt;
    logic          key_ok;
    logic          key_err;

    modport master (
        output downloading, ioctl_addr, ioctl_dout, ioctl_wr,
        input  key_din, key_we, key_cnt, key_ok, key_err
    );

    modport slave (
        input  downloading, ioctl_addr, ioctl_dout, ioctl_wr,
        output key_din, key_we, key_cnt, key_ok, key_err
    );
endinterface

// File: rtl/jtcps2_keyctrl.sv
// CPS2 key loader: sniffs downloader key bytes and replays them to keyload.
// Define JTCPS2_NOKEY_EN to feed an all-zero key when the download has none.
module jtcps2_keyctrl #(
    parameter int            AW        = 25,
    parameter logic [AW-1:0] KEY_START = '0,
    parameter int            KEY_LEN   = 20
) (
    input  logic             clk,
    input  logic             rst,
    jtcps2_keyctrl_if.slave  k
);
    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, DONE, ERR} state_t;

    localparam logic [4:0] LEN5 = 5'(KEY_LEN);

    state_t        st;
    logic          dl_l;
    logic [7:0]    mem [4];
    logic [1:0]    rd_ptr, wr_ptr;
    logic [2:0]    fcnt;
    logic [4:0]    acc_cnt;
    logic [AW-1:0] offs;
    logic          rise, fall, in_reg, acc;
    logic          empty, full;
    logic          pop, byp, zgen, push, drop;
`ifdef JTCPS2_NOKEY_EN
    logic          zmode;
`endif

    // unsigned wrap makes addresses below KEY_START fall out of range
    assign offs   = k.ioctl_addr - KEY_START;
    assign in_reg = offs < AW'(KEY_LEN);
    assign rise   = k.downloading & ~dl_l;
    assign fall   = ~k.downloading & dl_l;
    assign acc    = k.ioctl_wr & k.downloading & in_reg
                  & (rise | (acc_cnt < LEN5));
    assign empty  = fcnt == 3'd0;
    assign full   = fcnt == 3'd4;

    // an idle feeder with an empty FIFO forwards the incoming byte directly
    always_comb begin
        pop  = 1'b0;
        byp  = 1'b0;
        zgen = 1'b0;
        if (!rise && !k.key_we) begin
            if (!empty)
                pop = 1'b1;
            else if (acc)
                byp = 1'b1;
`ifdef JTCPS2_NOKEY_EN
            else if (st == DRAIN && k.key_cnt != LEN5
                     && (zmode || k.key_cnt == 5'd0))
                zgen = 1'b1;
`endif
        end
    end

    assign push = acc & ~byp & ~rise;
    assign drop = push & full & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            dl_l      <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fcnt      <= '0;
            acc_cnt   <= '0;
            for (int i = 0; i < 4; i++)
                mem[i] <= '0;
            k.key_din <= '0;
            k.key_we  <= 1'b0;
            k.key_cnt <= '0;
            k.key_ok  <= 1'b0;
            k.key_err <= 1'b0;
`ifdef JTCPS2_NOKEY_EN
            zmode     <= 1'b0;
`endif
        end else begin
            dl_l <= k.downloading;
            if (rise) begin
                st        <= LOAD;
                k.key_ok  <= 1'b0;
                k.key_err <= 1'b0;
                k.key_cnt <= '0;
                k.key_we  <= 1'b0;
                rd_ptr    <= '0;
                wr_ptr    <= {1'b0, acc};
                fcnt      <= {2'b0, acc};
                acc_cnt   <= {4'b0, acc};
                if (acc)
                    mem[0] <= k.ioctl_dout;
`ifdef JTCPS2_NOKEY_EN
                zmode     <= 1'b0;
`endif
            end else begin
                if (acc)
                    acc_cnt <= acc_cnt + 5'd1;
                k.key_we <= pop | byp | zgen;
                if (pop) begin
                    k.key_din <= mem[rd_ptr];
                    rd_ptr    <= rd_ptr + 2'd1;
                end else if (byp) begin
                    k.key_din <= k.ioctl_dout;
                end else if (zgen) begin
                    k.key_din <= 8'h00;
                end
                if (pop | byp | zgen)
                    k.key_cnt <= k.key_cnt + 5'd1;
                if (push && !drop) begin
                    mem[wr_ptr] <= k.ioctl_dout;
                    wr_ptr      <= wr_ptr + 2'd1;
                end
                if (drop)
                    k.key_err <= 1'b1;
                fcnt <= fcnt + {2'b0, push & ~drop} - {2'b0, pop};
`ifdef JTCPS2_NOKEY_EN
                if (zgen)
                    zmode <= 1'b1;
`endif
                unique case (st)
                    LOAD: if (fall) st <= DRAIN;
                    DRAIN: begin
                        if (empty && !k.key_we && !zgen) begin
                            if (k.key_cnt == LEN5) begin
                                st       <= DONE;
                                k.key_ok <= 1'b1;
                            end else begin
                                st        <= ERR;
                                k.key_err <= 1'b1;
                                k.key_ok  <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jtcps2_keyctrl.sv
// Scoreboard bench for jtcps2_keyctrl: expected key bytes queued at capture.
// Honours JTCPS2_NOKEY_EN to pick the no-key expectation.
module tb_jtcps2_keyctrl;
    localparam int AW = 25;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtcps2_keyctrl_if #(.AW(AW)) k();

    jtcps2_keyctrl #(.AW(AW), .KEY_START(25'h0), .KEY_LEN(20)) dut (
        .clk (clk),
        .rst (rst),
        .k   (k.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_pulse = 0;
    int p0 = 0;
    logic [7:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // spec-level capture model: acceptance, 4-deep occupancy, drops
    bit m_dl, m_we, m_rise, m_acc_ok, m_pop, m_byp;
    int m_acc, m_occ;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_dl = 0; m_we = 0; m_acc = 0; m_occ = 0;
            sb.delete();
        end else begin
            m_rise = k.downloading && !m_dl;
            m_acc_ok = k.ioctl_wr && k.downloading && (k.ioctl_addr < 25'd20)
                       && (m_rise || m_acc < 20);
            if (m_rise) begin
                chk("flush_empty", sb.size(), 0);
                sb.delete();
                m_acc = 0; m_occ = 0; m_we = 0;
                if (m_acc_ok) begin
                    m_acc = 1; m_occ = 1;
                    sb.push_back(k.ioctl_dout);
                end
            end else begin
                m_pop = !m_we && (m_occ > 0 || m_acc_ok);
                m_byp = m_pop && m_occ == 0;
                if (m_acc_ok) m_acc++;
                if (m_byp)
                    sb.push_back(k.ioctl_dout);
                else if (m_acc_ok && !(m_occ == 4 && !m_pop)) begin
                    m_occ++;
                    sb.push_back(k.ioctl_dout);
                end
                if (m_pop && !m_byp) m_occ--;
                m_we = m_pop;
            end
            m_dl = k.downloading;
        end
    end

    bit prev_we = 0;
    logic [7:0] exp_b;
    always @(negedge clk) begin
        if (!rst && k.key_we) begin
            chk("we_gap", prev_we, 0);
            if (sb.size() == 0)
                chk("sb_underrun", 1, 0);
            else begin
                exp_b = sb.pop_front();
                chk("key_din", k.key_din, exp_b);
            end
            chk("cnt_step", k.key_cnt, n_pulse - p0 + 1);
            n_pulse++;
        end
        prev_we = k.key_we;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
        k.ioctl_addr = a;
        k.ioctl_dout = d;
        k.ioctl_wr   = 1'b1;
        @(negedge clk);
        k.ioctl_wr   = 1'b0;
    endtask

    task automatic start_dl();
        p0 = n_pulse;
        k.downloading = 1'b1;
        @(negedge clk);
    endtask

    task automatic dl_keys(input int n, input int gap, input int base);
        for (int i = 0; i < n; i++) begin
            wr(AW'(i), 8'(base + i));
            idle(gap);
        end
    endtask

    task automatic wait_end();
        int n = 0;
        k.downloading = 1'b0;
        while (!((k.key_ok || k.key_err) && sb.size() == 0 && !k.key_we)
               && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("timeout", n < 500, 1);
        idle(4);
    endtask

    task automatic check_end(input string tag, input bit ok, input bit err,
                             input int cnt);
        chk({tag, "_ok"}, k.key_ok, ok);
        chk({tag, "_err"}, k.key_err, err);
        chk({tag, "_cnt"}, k.key_cnt, cnt);
        chk({tag, "_pulses"}, n_pulse - p0, cnt);
    endtask

    initial begin
        k.downloading = 0;
        k.ioctl_addr  = '0;
        k.ioctl_dout  = '0;
        k.ioctl_wr    = 0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_din", k.key_din, 0);
        chk("rst_we", k.key_we, 0);
        chk("rst_cnt", k.key_cnt, 0);
        chk("rst_ok", k.key_ok, 0);
        chk("rst_err", k.key_err, 0);

        // full key, paced writes
        start_dl();
        dl_keys(20, 1, 1);
        wait_end();
        check_end("full", 1, 0, 20);
        chk("din_hold", k.key_din, 8'h14);

        // interleaved foreign writes, tail outside region, surplus in region
        start_dl();
        for (int i = 0; i < 20; i++) begin
            wr(25'h100 + AW'(i), 8'hEE);
            wr(AW'(i), 8'(8'h40 + i));
            idle(2);
        end
        for (int j = 20; j <= 30; j++) wr(AW'(j), 8'h99);
        for (int j = 0; j < 3; j++) wr(AW'(j), 8'h77);
        wait_end();
        check_end("inter", 1, 0, 20);

        // short download then full reload
        start_dl();
        dl_keys(12, 1, 8'h60);
        wait_end();
        check_end("short", 0, 1, 12);
        start_dl();
        dl_keys(20, 1, 8'h20);
        wait_end();
        check_end("reload", 1, 0, 20);

        // back-to-back writes overrun the 4-entry buffer
        start_dl();
        dl_keys(20, 0, 8'hA0);
        wait_end();
        check_end("ovf", 0, 1, 14);

        // async reset mid-feed
        start_dl();
        for (int i = 0; i < 20; i++) begin
            wr(AW'(i), 8'(8'hC0 + i));
            if (n_pulse - p0 >= 7) break;
            idle(1);
        end
        chk("pre_rst_pulses", n_pulse - p0, 7);
        #2 rst = 1'b1;
        k.downloading = 1'b0;
        #1;
        chk("arst_we", k.key_we, 0);
        chk("arst_din", k.key_din, 0);
        chk("arst_cnt", k.key_cnt, 0);
        chk("arst_ok", k.key_ok, 0);
        chk("arst_err", k.key_err, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        start_dl();
        dl_keys(20, 1, 8'h50);
        wait_end();
        check_end("post_rst", 1, 0, 20);

        // re-download from DONE
        k.downloading = 1'b1;
        chk("ok_hold", k.key_ok, 1);
        @(posedge clk);
        #1;
        chk("entry_ok", k.key_ok, 0);
        chk("entry_cnt", k.key_cnt, 0);
        @(negedge clk);
        p0 = n_pulse;
        dl_keys(20, 1, 8'h80);
        wait_end();
        check_end("redl", 1, 0, 20);

        // download carrying no key bytes
        start_dl();
        for (int i = 0; i < 5; i++) wr(25'h200 + AW'(i), 8'h5A);
`ifdef JTCPS2_NOKEY_EN
        for (int i = 0; i < 20; i++) sb.push_back(8'h00);
        wait_end();
        check_end("nokey", 1, 0, 20);
`else
        wait_end();
        check_end("nokey", 0, 1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
